hdmi_pattern_gen: RTL and testbench

- Parametrised video timing and test-pattern generator in the pixel-clock domain, feeding `red`/`green`/`blue` plus sync/enable into the HDMI transceiver.
- Generalises the fixed solid-colour HDMI bring-up to:
  - any CEA/VESA timing via parameters;
  - configurable sync polarity and colour depth;
  - four runtime-selectable patterns, switched glitch-free at frame boundaries.

---
 rtl/hdmi_pattern_gen.sv | 205 ++++++++++++++++++++
 tb/tb_hdmi_pattern_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pattern_gen.sv
// Raster timing and test-pattern generator in the pixel-clock domain.
// One registered output stage keeps rgb, de, syncs, frame_start and x/y mutually aligned.
module hdmi_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_W    = 8,
  parameter int CHECK_LOG2 = 5,
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic               clk_low,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] solid_red,
  input  logic [COLOR_W-1:0] solid_green,
  input  logic [COLOR_W-1:0] solid_blue,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               frame_start,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  logic [HW-1:0]      h_q, h_d;
  logic [VW-1:0]      v_q, v_d;
  logic               act_q, act_d;
  logic [1:0]         mode_q, mode_d;
  logic [COLOR_W-1:0] sol_r_q, sol_r_d, sol_g_q, sol_g_d, sol_b_q, sol_b_d;

  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic               de_q, de_d, fs_q, fs_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;

  int                 h_int, v_int, bar_i;
  logic               line_end, frame_end, shadow_load;
  logic               in_active, hs_on, vs_on, checker_on;
  logic [2:0]         bar;
  logic [COLOR_W-1:0] grad, pix_r, pix_g, pix_b;

  always_comb begin
    h_int     = int'(h_q);
    v_int     = int'(v_q);
    line_end  = (h_int == H_TOTAL - 1);
    frame_end = line_end && (v_int == V_TOTAL - 1);
    in_active = (h_int < H_ACTIVE) && (v_int < V_ACTIVE);
    hs_on     = (h_int >= H_ACTIVE + H_FP) && (h_int < H_ACTIVE + H_FP + H_SYNC);
    vs_on     = (v_int >= V_ACTIVE + V_FP) && (v_int < V_ACTIVE + V_FP + V_SYNC);
  end

  // act_q doubles as the reset-release retiming flop: counters only move once it is set,
  // so the first edge after release/enable leaves them parked at (0,0).
  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    act_d = enable;
    if (!enable) begin
      h_d = '0;
      v_d = '0;
    end else if (act_q) begin
      if (line_end) begin
        h_d = '0;
        v_d = frame_end ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_comb begin
    shadow_load = !enable || (act_q && frame_end);
    mode_d      = shadow_load ? mode        : mode_q;
    sol_r_d     = shadow_load ? solid_red   : sol_r_q;
    sol_g_d     = shadow_load ? solid_green : sol_g_q;
    sol_b_d     = shadow_load ? solid_blue  : sol_b_q;
  end

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    bar_i = h_int / BAR_W;
    if (bar_i > 7) bar_i = 7;
    bar        = 3'(bar_i);
    grad       = COLOR_W'(h_q);
    checker_on = h_q[CHECK_LOG2] ^ v_q[CHECK_LOG2];
    case (mode_q)
      2'd0: begin
        pix_r = sol_r_q;
        pix_g = sol_g_q;
        pix_b = sol_b_q;
      end
      // Bar index bits map straight onto the white..black colour order.
      2'd1: begin
        pix_r = {COLOR_W{~bar[1]}};
        pix_g = {COLOR_W{~bar[2]}};
        pix_b = {COLOR_W{~bar[0]}};
      end
      2'd2: begin
        pix_r = grad;
        pix_g = grad;
        pix_b = grad;
      end
      default: begin
        pix_r = {COLOR_W{checker_on}};
        pix_g = {COLOR_W{checker_on}};
        pix_b = {COLOR_W{checker_on}};
      end
    endcase
  end

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    hsync_d = ~HSYNC_POL;
    vsync_d = ~VSYNC_POL;
    de_d    = 1'b0;
    fs_d    = 1'b0;
    x_d     = '0;
    y_d     = '0;
    if (act_q) begin
      if (hs_on) hsync_d = HSYNC_POL;
      if (vs_on) vsync_d = VSYNC_POL;
      if (in_active) begin
        red_d   = pix_r;
        green_d = pix_g;
        blue_d  = pix_b;
        de_d    = 1'b1;
        fs_d    = (h_int == 0) && (v_int == 0);
        x_d     = XW'(h_q);
        y_d     = YW'(v_q);
      end
    end
  end

  always_ff @(posedge clk_low or negedge reset_n) begin
    if (!reset_n) begin
      h_q     <= '0;
      v_q     <= '0;
      act_q   <= 1'b0;
      mode_q  <= '0;
      sol_r_q <= '0;
      sol_g_q <= '0;
      sol_b_q <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      act_q   <= act_d;
      mode_q  <= mode_d;
      sol_r_q <= sol_r_d;
      sol_g_q <= sol_g_d;
      sol_b_q <= sol_b_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign x           = x_q;
  assign y           = y_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen on a 24x12 raster: per-cycle frame-position model,
// pattern vector table and hand-built sequences for reset, enable and mode switching.
module tb_hdmi_pattern_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk_low = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable  = 1'b0;
  logic [1:0] mode    = 2'd0;
  logic [7:0] solid_red = 8'd0, solid_green = 8'd0, solid_blue = 8'd0;
  logic [7:0] red, green, blue;
  logic       hsync, vsync, de, frame_start;
  logic [3:0] x;
  logic [2:0] y;

  hdmi_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(8), .CHECK_LOG2(2)
  ) dut (
    .clk_low(clk_low), .reset_n(reset_n), .enable(enable), .mode(mode),
    .solid_red(solid_red), .solid_green(solid_green), .solid_blue(solid_blue),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
    .de(de), .frame_start(frame_start), .x(x), .y(y)
  );

  always #5 clk_low = ~clk_low;

  int n_pass = 0;
  int n_total = 0;

  // Reference: a single frame position p in 0..FT-1 plus a running flag and shadow copy.
  int         m_p, m_mode, m_sr, m_sg, m_sb;
  bit         m_act;
  logic [7:0] e_r, e_g, e_b;
  logic       e_hs, e_vs, e_de, e_fs;
  int         e_x, e_y;
  logic [2:0] bar_rgb [8];

  typedef struct {
    int         md;
    logic [7:0] sr, sg, sb;
    int         px, py;
    logic [23:0] exp_rgb;
  } vec_t;
  vec_t vecs [18];

  logic [23:0] cap [VA][HA];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_reset();
    m_p = 0; m_act = 0; m_mode = 0; m_sr = 0; m_sg = 0; m_sb = 0;
    e_r = 0; e_g = 0; e_b = 0; e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_x = 0; e_y = 0;
  endfunction

  function automatic void model_edge();
    int h, v, b;
    bit on;
    logic [2:0] c;
    h  = m_p % HT;
    v  = m_p / HT;
    on = m_act && (h < HA) && (v < VA);
    e_de = on;
    e_fs = on && (h == 0) && (v == 0);
    e_x  = on ? h : 0;
    e_y  = on ? v : 0;
    e_hs = !(m_act && (h >= HA + HF) && (h < HA + HF + HS));
    e_vs = !(m_act && (v >= VA + VF) && (v < VA + VF + VS));
    e_r = 0; e_g = 0; e_b = 0;
    if (on) begin
      case (m_mode)
        0: begin e_r = 8'(m_sr); e_g = 8'(m_sg); e_b = 8'(m_sb); end
        1: begin
          b = h / (HA / 8);
          if (b > 7) b = 7;
          c = bar_rgb[b];
          e_r = c[2] ? 8'hFF : 8'h00;
          e_g = c[1] ? 8'hFF : 8'h00;
          e_b = c[0] ? 8'hFF : 8'h00;
        end
        2: begin e_r = 8'(h % 256); e_g = 8'(h % 256); e_b = 8'(h % 256); end
        default: begin
          if ((((h >> 2) & 1) ^ ((v >> 2) & 1)) != 0) begin
            e_r = 8'hFF; e_g = 8'hFF; e_b = 8'hFF;
          end
        end
      endcase
    end
    if (!enable || (m_act && m_p == FT - 1)) begin
      m_mode = int'(mode); m_sr = int'(solid_red); m_sg = int'(solid_green); m_sb = int'(solid_blue);
    end
    if (!enable) begin
      m_p = 0; m_act = 0;
    end else begin
      if (m_act) m_p = (m_p + 1) % FT;
      m_act = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk_low);
    if (!reset_n) model_reset();
    else model_edge();
    @(negedge clk_low);
    check($sformatf("pixel@p%0d", m_p),
          64'({red, green, blue, hsync, vsync, de, frame_start, x, y}),
          64'({e_r, e_g, e_b, e_hs, e_vs, e_de, e_fs, 4'(e_x), 3'(e_y)}));
  endtask

  task automatic wait_fs(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < limit);
    if (!frame_start) check("fs_timeout", 64'(frame_start), 64'd1);
  endtask

  task automatic capture_frame();
    for (int i = 0; i < FT; i++) begin
      if (i > 0) tick();
      if (de) cap[y][x] = {red, green, blue};
    end
  endtask

  initial begin
    int n, k, de_n, hs_n, vs_n, t_fall, seen, bad, off_n, cur_md;
    logic [23:0] cur_sol;
    bit pde, phs, gap_done, hit;

    bar_rgb = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    vecs[0]  = '{0, 8'h0C, 8'h22, 8'h38,  5, 5, 24'h0C2238};
    vecs[1]  = '{0, 8'h0C, 8'h22, 8'h38, 15, 7, 24'h0C2238};
    vecs[2]  = '{1, 8'h00, 8'h00, 8'h00,  0, 0, 24'hFFFFFF};
    vecs[3]  = '{1, 8'h00, 8'h00, 8'h00,  1, 0, 24'hFFFFFF};
    vecs[4]  = '{1, 8'h00, 8'h00, 8'h00,  2, 0, 24'hFFFF00};
    vecs[5]  = '{1, 8'h00, 8'h00, 8'h00,  3, 6, 24'hFFFF00};
    vecs[6]  = '{1, 8'h00, 8'h00, 8'h00,  6, 2, 24'h00FF00};
    vecs[7]  = '{1, 8'h00, 8'h00, 8'h00,  8, 0, 24'hFF00FF};
    vecs[8]  = '{1, 8'h00, 8'h00, 8'h00, 10, 1, 24'hFF0000};
    vecs[9]  = '{1, 8'h00, 8'h00, 8'h00, 14, 7, 24'h000000};
    vecs[10] = '{1, 8'h00, 8'h00, 8'h00, 15, 3, 24'h000000};
    vecs[11] = '{2, 8'h00, 8'h00, 8'h00,  0, 0, 24'h000000};
    vecs[12] = '{2, 8'h00, 8'h00, 8'h00,  7, 3, 24'h070707};
    vecs[13] = '{2, 8'h00, 8'h00, 8'h00, 15, 7, 24'h0F0F0F};
    vecs[14] = '{3, 8'h00, 8'h00, 8'h00,  4, 0, 24'hFFFFFF};
    vecs[15] = '{3, 8'h00, 8'h00, 8'h00,  0, 0, 24'h000000};
    vecs[16] = '{3, 8'h00, 8'h00, 8'h00,  0, 4, 24'hFFFFFF};
    vecs[17] = '{3, 8'h00, 8'h00, 8'h00,  4, 4, 24'h000000};

    model_reset();
    #1 reset_n = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_de", 64'(de), 64'd0);
    check("rst_syncs", 64'({hsync, vsync}), 64'(2'b11));
    reset_n = 1'b1;

    wait_fs(10, n);
    check("first_fs_latency", 64'(n), 64'd2);
    wait_fs(FT + 100, n);
    check("fs_period", 64'(n), 64'(FT));

    de_n = 0; hs_n = 0; vs_n = 0; t_fall = -1; gap_done = 0;
    pde = de; phs = hsync;
    for (int i = 0; i < 2 * FT; i++) begin
      tick();
      de_n += int'(de);
      hs_n += int'(!hsync);
      vs_n += int'(!vsync);
      if (pde && !de) t_fall = i;
      if (phs && !hsync && t_fall >= 0 && !gap_done) begin
        check("de_to_hsync_gap", 64'(i - t_fall), 64'd2);
        gap_done = 1;
      end
      pde = de; phs = hsync;
    end
    check("de_cycles_2frames", 64'(de_n), 64'(2 * HA * VA));
    check("hsync_low_2frames", 64'(hs_n), 64'(2 * HS * VT));
    check("vsync_low_2frames", 64'(vs_n), 64'(2 * VS * HT));

    cur_md = -1; cur_sol = '0;
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].md != cur_md || {vecs[i].sr, vecs[i].sg, vecs[i].sb} != cur_sol) begin
        mode = 2'(vecs[i].md);
        solid_red = vecs[i].sr; solid_green = vecs[i].sg; solid_blue = vecs[i].sb;
        wait_fs(FT + 100, n);
        wait_fs(FT + 100, n);
        capture_frame();
        cur_md = vecs[i].md;
        cur_sol = {vecs[i].sr, vecs[i].sg, vecs[i].sb};
      end
      check($sformatf("vec%0d_m%0d_x%0d_y%0d", i, vecs[i].md, vecs[i].px, vecs[i].py),
            64'(cap[vecs[i].py][vecs[i].px]), 64'(vecs[i].exp_rgb));
    end

    mode = 2'd0; solid_red = 8'd12; solid_green = 8'd34; solid_blue = 8'd56;
    wait_fs(FT + 100, n);
    wait_fs(FT + 100, n);
    k = 0;
    while (!(de && y == 3'd4 && x == 4'd0) && k < 2 * FT) begin tick(); k++; end
    check("switch_at_line4", 64'({de, y, x}), 64'({1'b1, 3'd4, 4'd0}));
    mode = 2'd3;
    seen = 0; bad = 0; hit = 0;
    for (int i = 0; i < FT + 10; i++) begin
      tick();
      if (frame_start) begin hit = 1; break; end
      if (de) begin
        seen++;
        if ({red, green, blue} != {8'd12, 8'd34, 8'd56}) bad++;
      end
    end
    check("switch_fs_seen", 64'(hit), 64'd1);
    check("switch_rest_pixels", 64'(seen), 64'(HA * 4 - 1));
    check("switch_rest_bad", 64'(bad), 64'd0);
    check("switch_x0y0_black", 64'({de, red, green, blue}), 64'({1'b1, 24'h000000}));
    for (int i = 0; i < 4; i++) tick();
    check("switch_x4y0_white", 64'({de, x, y, red, green, blue}), 64'({1'b1, 4'd4, 3'd0, 24'hFFFFFF}));

    k = 0;
    while (!(m_act && m_p == 3 * HT + 5) && k < 2 * FT) begin tick(); k++; end
    enable = 1'b0;
    tick();
    check("disable_last_pixel", 64'({de, x, y}), 64'({1'b1, 4'd5, 3'd3}));
    tick();
    check("disable_idle", 64'({de, hsync, vsync, frame_start, red, green, blue}), 64'({4'b0110, 24'h0}));
    tick();
    tick();
    enable = 1'b1;
    wait_fs(10, n);
    check("reenable_fs_latency", 64'(n), 64'd2);

    mode = 2'd2;
    wait_fs(FT + 100, n);
    wait_fs(FT + 100, n);
    k = 0;
    while (!(de && x == 4'd6) && k < FT) begin tick(); k++; end
    check("gradient_before_reset", 64'({de, red}), 64'({1'b1, 8'd6}));
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_idle", 64'({red, green, blue, de, hsync, vsync}), 64'({24'h0, 3'b011}));
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
    wait_fs(10, n);
    check("post_reset_fs_latency", 64'(n), 64'd2);
    for (int i = 0; i < 5; i++) tick();
    check("post_reset_shadow_mode0", 64'({de, x, red, green, blue}), 64'({1'b1, 4'd5, 24'h0}));

    off_n = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        mode = 2'($urandom);
        solid_red = 8'($urandom); solid_green = 8'($urandom); solid_blue = 8'($urandom);
      end
      if (enable && $urandom_range(0, 299) == 0) begin
        enable = 1'b0;
        off_n = int'($urandom_range(1, 10));
      end else if (!enable) begin
        off_n--;
        if (off_n <= 0) enable = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
